// File: rtl/w4823_fir_if.sv
// w4823_fir_if: sample, coefficient and result signals of the serial FIR.
interface w4823_fir_if;
    logic signed [15:0] din;
    logic               valid_in;
    logic signed [16:0] cin;
    logic [5:0]         caddr;
    logic               cload;
    logic signed [15:0] dout;
    logic               valid;
    modport master (output din, valid_in, cin, caddr, cload, input dout, valid);
    modport slave (input din, valid_in, cin, caddr, cload, output dout, valid);
endinterface

// File: rtl/w4823_fir.sv
// w4823_fir: 64-tap serial FIR, one MAC per clk2 cycle, samples from clk1 ticks or valid_in.
// Define W4823_FIR_SAT_EN to saturate the output instead of wrapping it.
module w4823_fir (
    input  logic clk2,
    input  logic rst_n,
    input  logic clk1,
    w4823_fir_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nx;
    logic sync1, sync2, sync3, tick, req;
    logic [5:0] wptr, k, ridx;
    logic signed [38:0] acc;
    logic signed [32:0] prod;
    logic signed [15:0] scaled, dout_r;
    logic valid_r;
    logic signed [15:0] dline [64];
    logic signed [16:0] cmem [64];

    // clk1 is asynchronous: two flops to resolve metastability, a third for the rising edge
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk1;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;
    assign req  = tick | bus.valid_in;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && req)              state_nx = MAC;
        else if (state == MAC && k == 6'd63)   state_nx = OUT;
        else if (state == OUT)                 state_nx = IDLE;
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) cmem[i] <= '0;
        end else if (bus.cload) begin
            cmem[bus.caddr] <= bus.cin;
        end
    end

    // wptr already points past the newest sample once MAC starts
    assign ridx = wptr - 6'd1 - k;
    assign prod = 33'(dline[ridx]) * 33'(cmem[k]);

`ifdef W4823_FIR_SAT_EN
    logic signed [22:0] sh;
    assign sh = acc[38:16];
    assign scaled = (sh > 23'sd32767) ? 16'sh7fff :
                    (sh < -23'sd32768) ? 16'sh8000 : sh[15:0];
`else
    assign scaled = acc[31:16];
`endif

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) dline[i] <= '0;
            wptr    <= '0;
            k       <= '0;
            acc     <= '0;
            dout_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= (state == OUT);
            if (state == OUT) dout_r <= scaled;
            if (state == IDLE && req) begin
                dline[wptr] <= bus.din;
                wptr        <= wptr + 6'd1;
                acc         <= '0;
                k           <= '0;
            end
            if (state == MAC) begin
                acc <= acc + 39'(prod);
                k   <= k + 6'd1;
            end
        end
    end

    assign bus.dout  = dout_r;
    assign bus.valid = valid_r;
endmodule

// File: tb/tb_w4823_fir.sv
// tb_w4823_fir: table-driven and randomized checks of w4823_fir against a convolution model.
module tb_w4823_fir;
    logic clk2 = 1'b0;
    logic rst_n = 1'b0;
    logic clk1 = 1'b0;
    w4823_fir_if bus();
    w4823_fir dut (.clk2(clk2), .rst_n(rst_n), .clk1(clk1), .bus(bus));
    always #5 clk2 = ~clk2;

    typedef struct {
        longint din;
        bit     use_tick;
        longint exp;
    } vec_t;
    vec_t imp[$];
    vec_t dc[$];
    int n_cmp = 0;
    int n_fail = 0;
    longint coef[64];
    longint xs[$];

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // y[n] = sum c[k]*x[n-k], floor-shifted by 16, then saturated or wrapped to 16 bits
    function automatic longint model_push(input longint x);
        longint acc, sh, w;
        acc = 0;
        xs.push_front(x);
        if (xs.size() > 64) void'(xs.pop_back());
        for (int i = 0; i < xs.size(); i++) acc += coef[i] * xs[i];
        sh = acc >>> 16;
`ifdef W4823_FIR_SAT_EN
        w = (sh > 32767) ? 32767 : (sh < -32768) ? -32768 : sh;
`else
        w = sh & 65535;
        if (w >= 32768) w -= 65536;
`endif
        return w;
    endfunction

    task automatic model_clear();
        xs.delete();
        foreach (coef[i]) coef[i] = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk2);
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.cload = 1'b0;
        bus.din = '0;
        clk1 = 1'b0;
        repeat (3) @(negedge clk2);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic wcoef(input int a, input longint c);
        @(negedge clk2);
        bus.cload = 1'b1;
        bus.caddr = 6'(a);
        bus.cin = 17'(c);
        @(negedge clk2);
        bus.cload = 1'b0;
        coef[a % 64] = c;
    endtask

    task automatic feed_chk(input string name, input longint d, input bit use_tick,
                            input bit has_exp, input longint exp);
        longint m, got;
        int lat;
        m = model_push(d);
        @(negedge clk2);
        bus.din = 16'(d);
        if (use_tick) clk1 = 1'b1;
        else bus.valid_in = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk2);
            bus.valid_in = 1'b0;
            if (i == 6) clk1 = 1'b0;
            if (bus.valid) begin
                lat = i;
                break;
            end
        end
        clk1 = 1'b0;
        got = bus.dout;
        if (use_tick) check({name, " tick latency ok"}, longint'(lat >= 67 && lat <= 69), 1);
        else check({name, " latency"}, lat, 66);
        check({name, " vs model"}, got, m);
        if (has_exp) check({name, " vs table"}, got, exp);
        @(negedge clk2);
        check({name, " valid one cycle"}, bus.valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, nval, next_free;
        longint expq[int];
        longint d;
        for (int n = 0; n < 65; n++)
            imp.push_back('{din: (n == 0) ? 16384 : 0, use_tick: 1'b1, exp: (n < 64) ? n * 256 : 0});
        for (int n = 0; n < 70; n++)
            dc.push_back('{din: 1600, use_tick: 1'b0, exp: ((n + 1 < 64) ? n + 1 : 64) * 100});
        bus.din = '0;
        bus.valid_in = 1'b0;
        bus.cin = '0;
        bus.caddr = '0;
        bus.cload = 1'b0;

        #12;
        check("reset dout", bus.dout, 0);
        check("reset valid", bus.valid, 0);
        reset_dut();

        // impulse via clk1 ticks
        for (int i = 0; i < 64; i++) wcoef(i, i * 1024);
        foreach (imp[i]) feed_chk($sformatf("impulse[%0d]", i), imp[i].din, imp[i].use_tick, 1'b1, imp[i].exp);

        // DC ramp via valid_in
        reset_dut();
        for (int i = 0; i < 64; i++) wcoef(i, 4096);
        foreach (dc[i]) feed_chk($sformatf("dc[%0d]", i), dc[i].din, dc[i].use_tick, 1'b1, dc[i].exp);

        // asynchronous reset in the middle of a MAC run
        @(negedge clk2);
        bus.din = 16'sd999;
        bus.valid_in = 1'b1;
        @(negedge clk2);
        bus.valid_in = 1'b0;
        repeat (20) @(negedge clk2);
        #2 rst_n = 1'b0;
        #1;
        check("async reset dout", bus.dout, 0);
        check("async reset valid", bus.valid, 0);
        model_clear();
        repeat (3) @(negedge clk2);
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk2);
            if (bus.valid) nval++;
        end
        check("aborted run valids", nval, 0);
        feed_chk("after reset zero coef", 12345, 1'b0, 1'b1, 0);

        // saturation / wrap
        reset_dut();
        for (int i = 0; i < 64; i++) wcoef(i, 65535);
        for (int n = 0; n < 64; n++)
`ifdef W4823_FIR_SAT_EN
            feed_chk($sformatf("sat pos[%0d]", n), 32767, 1'b0, n == 63, 32767);
`else
            feed_chk($sformatf("wrap pos[%0d]", n), 32767, 1'b0, n == 63, -96);
`endif
        reset_dut();
        for (int i = 0; i < 64; i++) wcoef(i, 65535);
        for (int n = 0; n < 64; n++)
`ifdef W4823_FIR_SAT_EN
            feed_chk($sformatf("sat neg[%0d]", n), -32768, 1'b0, n == 63, -32768);
`else
            feed_chk($sformatf("wrap neg[%0d]", n), -32768, 1'b0, n == 63, 32);
`endif

        // overrun: valid_in every 10 cycles, only requests arriving while idle count
        reset_dut();
        for (int i = 0; i < 64; i++) wcoef(i, longint'($urandom_range(0, 131071)) - 65536);
        next_free = 0;
        nacc = 0;
        nval = 0;
        for (int c = 0; c <= 230; c++) begin
            @(negedge clk2);
            check($sformatf("overrun valid @%0d", c), bus.valid, longint'(expq.exists(c)));
            if (bus.valid) nval++;
            if (expq.exists(c)) check($sformatf("overrun dout @%0d", c), bus.dout, expq[c]);
            bus.valid_in = (c % 10 == 0) && (c <= 200);
            if (bus.valid_in) begin
                d = longint'($urandom_range(0, 65535)) - 32768;
                bus.din = 16'(d);
                if (c >= next_free) begin
                    expq[c + 66] = model_push(d);
                    next_free = c + 66;
                    nacc++;
                end
            end
        end
        bus.valid_in = 1'b0;
        check("overrun valid count", nval, nacc);

        // address wrap: 65th write lands on c[0]
        reset_dut();
        for (int i = 0; i <= 64; i++) wcoef(i, (i == 64) ? 4000 : (i + 1) * 4);
        feed_chk("wrap c0", 16384, 1'b0, 1'b1, 1000);
        feed_chk("wrap c1", 0, 1'b0, 1'b1, 2);

        // randomized coefficients and samples
        reset_dut();
        for (int i = 0; i < 64; i++) wcoef(i, longint'($urandom_range(0, 131071)) - 65536);
        for (int n = 0; n < 30; n++)
            feed_chk($sformatf("random[%0d]", n), longint'($urandom_range(0, 65535)) - 32768,
                     1'($urandom_range(0, 1)), 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
